cpu_run_monitor: RTL and testbench
==================================

CPU_RUN_MONITOR -- requirements
Module: cpu_run_monitor

Interface
REQ-001 SHALL have parameter XLEN, default 32: width of the monitored PC.
REQ-002 SHALL have parameter CNT_W, default 32: width of the cycle and instruction counters.
REQ-003 SHALL have parameter RST_CYCLES, default 2, legal range 1..255: number of cycles the CPU reset is held.
REQ-004 SHALL have parameter TIMEOUT, default 1000, legal range 1..2^CNT_W-1: RUN cycle budget.
REQ-005 SHALL have parameter HALT_REPEAT, default 4, legal range 1..255: number of consecutive repeated valid PCs that declares a halt.
REQ-006 clk  input  1  sole clock; all state updates on the rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-low.
REQ-008 start  input  1  single-cycle request to begin a run.
REQ-009 pc_valid  input  1  pc_in carries a retired-instruction PC this cycle.
REQ-010 pc_in  input  XLEN  PC of the CPU under test.
REQ-011 cpu_rst  output  1  active-high reset driven to the CPU.
REQ-012 running  output  1  high while in RUN.
REQ-013 done  output  1  high in HALTED or TIMEOUT.
REQ-014 pass  output  1  high in HALTED.
REQ-015 fail  output  1  high in TIMEOUT.
REQ-016 cycle_cnt  output  CNT_W  number of cycles spent in RUN.
REQ-017 instr_cnt  output  CNT_W  number of valid PCs seen in RUN.
REQ-018 last_pc  output  XLEN  most recent valid PC.

Function
REQ-019 SHALL implement a registered FSM with the states IDLE, RESET, RUN, HALTED and TIMEOUT.
REQ-020 All outputs SHALL be registered or decoded directly from the state register, with no combinational path from any input to any output.
REQ-021 IDLE: on start=1 the FSM SHALL go to RESET, clear cycle_cnt, instr_cnt, last_pc and the internal repeat counter, and clear the have_pc flag.
REQ-022 RESET: cpu_rst SHALL be 1 for exactly RST_CYCLES cycles, after which the FSM SHALL go to RUN; start SHALL be ignored in this state.
REQ-023 cpu_rst SHALL be 1 in IDLE and RESET, and 0 in RUN, HALTED and TIMEOUT.
REQ-024 RUN: cycle_cnt SHALL increment by 1 every cycle.
REQ-025 RUN: instr_cnt SHALL increment by 1 on each cycle with pc_valid=1.
REQ-026 Both counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-027 RUN, pc_valid=1: last_pc SHALL be loaded with pc_in and have_pc SHALL be set to 1.
REQ-028 RUN, pc_valid=1, have_pc=1 and pc_in==last_pc: the repeat counter SHALL increment; when pc_in!=last_pc it SHALL clear to 0.
REQ-029 Cycles with pc_valid=0 SHALL leave last_pc, have_pc and the repeat counter unchanged.
REQ-030 The first valid PC after RESET SHALL NOT be compared against last_pc.
REQ-031 Halt condition: a valid repeat occurring while the repeat counter equals HALT_REPEAT-1 SHALL move the FSM to HALTED on the next edge.
REQ-032 Timeout condition: cycle_cnt equal to TIMEOUT-1 while in RUN SHALL move the FSM to TIMEOUT on the next edge, so the final cycle_cnt is TIMEOUT.
REQ-033 When the halt and timeout conditions occur in the same cycle, HALTED SHALL win.
REQ-034 start during RUN SHALL be ignored.
REQ-035 In HALTED and TIMEOUT, the counters and last_pc SHALL be frozen.
REQ-036 start in HALTED or TIMEOUT SHALL re-enter RESET with the same clearing as REQ-021.
REQ-037 The repeat counter SHALL be 8 bits wide and saturating.

Reset
REQ-038 rst=0 SHALL immediately, independent of clk, force state=IDLE, cpu_rst=1, running=0, done=0, pass=0, fail=0, cycle_cnt=0, instr_cnt=0, last_pc=0, repeat counter=0 and have_pc=0.
REQ-039 rst asserted mid-RUN SHALL abort the run with no residual status; the first start after rst returns to 1 SHALL behave as from power-up.

Verification (RST_CYCLES=2, TIMEOUT=20, HALT_REPEAT=3)
REQ-040 Power-up: rst=0 for 2 cycles, then release, then start pulsed at edge N -> cpu_rst=1 through edge N+2, running=1 from edge N+3, all counters 0 at entry to RUN.
REQ-041 Halt: valid PCs 0x0, 0x4, 0x8, 0xC, 0xC, 0xC, 0xC on consecutive cycles -> pass=1, done=1, fail=0, instr_cnt=7, last_pc=0xC, counters frozen afterwards.
REQ-042 Timeout: valid PCs incrementing by 4 every cycle -> fail=1 with cycle_cnt=20, pass=0, cpu_rst stays 0.
REQ-043 Gaps: valid PCs 0x10, 0x10 separated by pc_valid=0 cycles, then 0x10, 0x10 -> halt still declared; instr_cnt=4.
REQ-044 Tie: 16 distinct PCs, then 0x40 repeated so the halt condition coincides with cycle_cnt=19 -> pass=1, fail=0.
REQ-045 Abort and restart: rst pulsed low mid-RUN -> all outputs at reset values asynchronously; a following start then runs a clean halt test matching REQ-041.

Source files
------------

// File: rtl/cpu_run_monitor.sv
// cpu_run_monitor: holds a CPU in reset, runs it, and declares HALTED (repeated PC) or TIMEOUT.
// Ports: clk, rst (async active-low); start pulse; pc_valid/pc_in retired-PC stream;
//        cpu_rst to CPU; running/done/pass/fail status; cycle_cnt, instr_cnt, last_pc results.
module cpu_run_monitor #(
    parameter int          XLEN        = 32,
    parameter int          CNT_W       = 32,
    parameter int          RST_CYCLES  = 2,
    parameter int unsigned TIMEOUT     = 1000,
    parameter int          HALT_REPEAT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             pc_valid,
    input  logic [XLEN-1:0]  pc_in,
    output logic             cpu_rst,
    output logic             running,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt,
    output logic [XLEN-1:0]  last_pc
);
    typedef enum logic [2:0] {S_IDLE, S_RESET, S_RUN, S_HALTED, S_TIMEOUT} state_t;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [7:0]       REP_LAST = 8'(HALT_REPEAT - 1);
    localparam logic [7:0]       RST_LAST = 8'(RST_CYCLES - 1);
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cycle_q, cycle_d, instr_q, instr_d;
    logic [XLEN-1:0]  last_q, last_d;
    logic [7:0]       rep_q, rep_d, rcnt_q, rcnt_d;
    logic             have_q, have_d;
    logic             cpu_rst_q, cpu_rst_d, running_q, running_d;
    logic             pass_q, pass_d, fail_q, fail_d;
    logic             rep_hit, halt, tmo;
    // The first valid PC after RESET only primes last_pc; have_pc gates the compare.
    assign rep_hit = pc_valid && have_q && (pc_in == last_q);
    assign halt    = rep_hit && (rep_q == REP_LAST);
    assign tmo     = cycle_q == TMO_LAST;
    always_comb begin
        state_d = state_q;
        cycle_d = cycle_q;
        instr_d = instr_q;
        last_d  = last_q;
        rep_d   = rep_q;
        have_d  = have_q;
        rcnt_d  = rcnt_q;
        case (state_q)
            S_IDLE, S_HALTED, S_TIMEOUT: begin
                if (start) begin
                    state_d = S_RESET;
                    cycle_d = '0;
                    instr_d = '0;
                    last_d  = '0;
                    rep_d   = '0;
                    have_d  = 1'b0;
                    rcnt_d  = '0;
                end
            end
            S_RESET: begin
                rcnt_d  = rcnt_q + 8'd1;
                state_d = (rcnt_q == RST_LAST) ? S_RUN : S_RESET;
            end
            S_RUN: begin
                cycle_d = (cycle_q == CNT_MAX) ? cycle_q : cycle_q + 1'b1;
                if (pc_valid) begin
                    instr_d = (instr_q == CNT_MAX) ? instr_q : instr_q + 1'b1;
                    last_d  = pc_in;
                    have_d  = 1'b1;
                    rep_d   = rep_hit ? ((rep_q == 8'hff) ? rep_q : rep_q + 8'd1) : 8'd0;
                end
                // Halt takes priority when both end conditions land in the same cycle.
                state_d = halt ? S_HALTED : tmo ? S_TIMEOUT : S_RUN;
            end
            default: state_d = S_IDLE;
        endcase
        cpu_rst_d = (state_d == S_IDLE) || (state_d == S_RESET);
        running_d = state_d == S_RUN;
        pass_d    = state_d == S_HALTED;
        fail_d    = state_d == S_TIMEOUT;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cycle_q   <= '0;
            instr_q   <= '0;
            last_q    <= '0;
            rep_q     <= '0;
            have_q    <= 1'b0;
            rcnt_q    <= '0;
            cpu_rst_q <= 1'b1;
            running_q <= 1'b0;
            pass_q    <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cycle_q   <= cycle_d;
            instr_q   <= instr_d;
            last_q    <= last_d;
            rep_q     <= rep_d;
            have_q    <= have_d;
            rcnt_q    <= rcnt_d;
            cpu_rst_q <= cpu_rst_d;
            running_q <= running_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
        end
    end
    assign cpu_rst   = cpu_rst_q;
    assign running   = running_q;
    assign pass      = pass_q;
    assign fail      = fail_q;
    assign done      = pass_q | fail_q;
    assign cycle_cnt = cycle_q;
    assign instr_cnt = instr_q;
    assign last_pc   = last_q;
endmodule

// File: tb/tb_cpu_run_monitor.sv
// tb_cpu_run_monitor: directed bench for cpu_run_monitor with RST_CYCLES=2, TIMEOUT=20, HALT_REPEAT=3.
module tb_cpu_run_monitor;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        pc_valid = 1'b0;
    logic [31:0] pc_in = '0;
    logic        cpu_rst, running, done, pass, fail;
    logic [31:0] cycle_cnt, instr_cnt, last_pc;
    int          checks = 0;
    int          passed = 0;

    cpu_run_monitor #(.XLEN(32), .CNT_W(32), .RST_CYCLES(2), .TIMEOUT(20), .HALT_REPEAT(3)) dut (
        .clk(clk), .rst(rst), .start(start), .pc_valid(pc_valid), .pc_in(pc_in),
        .cpu_rst(cpu_rst), .running(running), .done(done), .pass(pass), .fail(fail),
        .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt), .last_pc(last_pc)
    );

    always #5 clk = ~clk;

    // status vector order: {cpu_rst, running, done, pass, fail}
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic v, input logic [31:0] pc);
        pc_valid = v;
        pc_in    = pc;
        step();
        pc_valid = 1'b0;
    endtask

    task automatic start_run(input bit hold);
        start = 1'b1;
        step();
        start = hold;
        checks++; if ({cpu_rst, running, done} !== 3'b100) $display("FAIL rst_cyc1: got %b exp 100", {cpu_rst, running, done}); else passed++;
        step();
        checks++; if ({cpu_rst, running, done} !== 3'b100) $display("FAIL rst_cyc2: got %b exp 100", {cpu_rst, running, done}); else passed++;
        step();
        start = 1'b0;
        checks++; if ({cpu_rst, running, done, pass, fail} !== 5'b01000) $display("FAIL run_entry: got %b exp 01000", {cpu_rst, running, done, pass, fail}); else passed++;
        checks++; if ({cycle_cnt, instr_cnt, last_pc} !== 96'd0) $display("FAIL run_entry_cnt: got %h exp 0", {cycle_cnt, instr_cnt, last_pc}); else passed++;
    endtask

    task automatic test_reset();
        step();
        checks++; if ({cpu_rst, running, done, pass, fail} !== 5'b10000) $display("FAIL reset_status: got %b exp 10000", {cpu_rst, running, done, pass, fail}); else passed++;
        checks++; if ({cycle_cnt, instr_cnt, last_pc} !== 96'd0) $display("FAIL reset_cnt: got %h exp 0", {cycle_cnt, instr_cnt, last_pc}); else passed++;
        step();
        rst = 1'b1;
        step();
        checks++; if ({cpu_rst, running, done} !== 3'b100) $display("FAIL idle_after_rst: got %b exp 100", {cpu_rst, running, done}); else passed++;
    endtask

    task automatic test_halt();
        logic [31:0] pcs [7] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'hC, 32'hC, 32'hC};
        start_run(1'b0);
        for (int i = 0; i < 6; i++) feed(1'b1, pcs[i]);
        checks++; if ({running, pass} !== 2'b10) $display("FAIL halt_not_yet: got %b exp 10", {running, pass}); else passed++;
        feed(1'b1, pcs[6]);
        checks++; if ({cpu_rst, running, done, pass, fail} !== 5'b00110) $display("FAIL halt_status: got %b exp 00110", {cpu_rst, running, done, pass, fail}); else passed++;
        checks++; if (instr_cnt !== 32'd7) $display("FAIL halt_instr: got %0d exp 7", instr_cnt); else passed++;
        checks++; if (cycle_cnt !== 32'd7) $display("FAIL halt_cycle: got %0d exp 7", cycle_cnt); else passed++;
        checks++; if (last_pc !== 32'hC) $display("FAIL halt_last_pc: got %h exp c", last_pc); else passed++;
        feed(1'b1, 32'h200);
        feed(1'b1, 32'h204);
        checks++; if ({instr_cnt, cycle_cnt, last_pc} !== {32'd7, 32'd7, 32'hC}) $display("FAIL halt_frozen: got %0d %0d %h exp 7 7 c", instr_cnt, cycle_cnt, last_pc); else passed++;
        checks++; if ({done, pass, fail} !== 3'b110) $display("FAIL halt_hold: got %b exp 110", {done, pass, fail}); else passed++;
    endtask

    task automatic test_timeout();
        start_run(1'b0);
        for (int i = 0; i < 19; i++) begin
            start = (i == 5);
            feed(1'b1, 32'(i * 4));
        end
        start = 1'b0;
        checks++; if ({running, cycle_cnt} !== {1'b1, 32'd19}) $display("FAIL tmo_before: got %b %0d exp 1 19", running, cycle_cnt); else passed++;
        feed(1'b1, 32'h4C);
        checks++; if ({cpu_rst, running, done, pass, fail} !== 5'b00101) $display("FAIL tmo_status: got %b exp 00101", {cpu_rst, running, done, pass, fail}); else passed++;
        checks++; if ({cycle_cnt, instr_cnt, last_pc} !== {32'd20, 32'd20, 32'h4C}) $display("FAIL tmo_cnt: got %0d %0d %h exp 20 20 4c", cycle_cnt, instr_cnt, last_pc); else passed++;
        step();
        step();
        checks++; if ({cpu_rst, fail, cycle_cnt} !== {2'b01, 32'd20}) $display("FAIL tmo_frozen: got %b %b %0d exp 0 1 20", cpu_rst, fail, cycle_cnt); else passed++;
    endtask

    task automatic test_gaps();
        start_run(1'b1);
        feed(1'b1, 32'h10);
        feed(1'b0, 32'h99);
        feed(1'b1, 32'h10);
        feed(1'b0, 32'h99);
        checks++; if (last_pc !== 32'h10) $display("FAIL gap_last_pc: got %h exp 10", last_pc); else passed++;
        feed(1'b1, 32'h10);
        feed(1'b0, 32'h0);
        checks++; if ({running, pass} !== 2'b10) $display("FAIL gap_not_yet: got %b exp 10", {running, pass}); else passed++;
        feed(1'b1, 32'h10);
        checks++; if ({done, pass, fail} !== 3'b110) $display("FAIL gap_halt: got %b exp 110", {done, pass, fail}); else passed++;
        checks++; if ({instr_cnt, cycle_cnt} !== {32'd4, 32'd7}) $display("FAIL gap_cnt: got %0d %0d exp 4 7", instr_cnt, cycle_cnt); else passed++;
    endtask

    task automatic test_tie();
        start_run(1'b0);
        for (int i = 0; i < 16; i++) feed(1'b1, 32'(i * 4));
        for (int i = 0; i < 3; i++) feed(1'b1, 32'h40);
        checks++; if ({running, cycle_cnt} !== {1'b1, 32'd19}) $display("FAIL tie_before: got %b %0d exp 1 19", running, cycle_cnt); else passed++;
        feed(1'b1, 32'h40);
        checks++; if ({done, pass, fail} !== 3'b110) $display("FAIL tie_status: got %b exp 110", {done, pass, fail}); else passed++;
        checks++; if ({cycle_cnt, instr_cnt, last_pc} !== {32'd20, 32'd20, 32'h40}) $display("FAIL tie_cnt: got %0d %0d %h exp 20 20 40", cycle_cnt, instr_cnt, last_pc); else passed++;
    endtask

    task automatic test_abort();
        start_run(1'b0);
        feed(1'b1, 32'h100);
        feed(1'b1, 32'h100);
        #3;
        rst = 1'b0;
        #1;
        checks++; if ({cpu_rst, running, done, pass, fail} !== 5'b10000) $display("FAIL abort_status: got %b exp 10000", {cpu_rst, running, done, pass, fail}); else passed++;
        checks++; if ({cycle_cnt, instr_cnt, last_pc} !== 96'd0) $display("FAIL abort_cnt: got %h exp 0", {cycle_cnt, instr_cnt, last_pc}); else passed++;
        step();
        rst = 1'b1;
        step();
        step();
        checks++; if ({cpu_rst, running} !== 2'b10) $display("FAIL abort_idle: got %b exp 10", {cpu_rst, running}); else passed++;
        test_halt();
    endtask

    initial begin
        test_reset();
        test_halt();
        test_timeout();
        test_gaps();
        test_tie();
        test_abort();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
